muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//
// Controls the multi-cycle multiply and divide datapaths and holds the
// architectural HI/LO registers.
//
// MULT/DIV requests from the control unit are turned into one-cycle start
// pulses for the multiplier or divider. The pipeline is stalled until the
// matching done (Stop) indication arrives or a watchdog expires. A completed
// operation commits its results into HI/LO. MTHI/MTLO writes load HI/LO
// directly, but only when the block is idle.
//
// Handshake semantics (all signals are sampled on the rising edge of Clock):
//   - OpMult/OpDiv are levels. They are examined only in IDLE. While a
//     request is present in IDLE, Stall is high in that same cycle, so the
//     pipeline holds the instruction until the request is taken.
//   - MultStart/DivStart are registered, one-cycle pulses. They are high in
//     the first cycle of the corresponding wait state.
//   - MultStop/DivStop mean "result valid this cycle". They are honoured only
//     in the matching wait state and are ignored everywhere else.
//   - Done/Error are one-cycle pulses. Stall is low in the cycle that carries
//     them, so the held instruction advances and sees the updated HI/LO.
//
// Parameters:
//   WIDTH    operand, HI and LO width
//   TIMEOUT  cycles a wait state may last before the operation is aborted
//            (>= 2)
//
// Ports:
//   Clock, Reset             system clock; asynchronous active-low reset
//   OpMult, OpDiv            multiply / divide request (level)
//   DivisorZero              divisor is zero, qualifies OpDiv
//   HiWrite, LoWrite         MTHI / MTLO strobes
//   WriteData                data for HiWrite / LoWrite
//   MultStop, MultHI/LO      multiplier done flag and results
//   DivStop, DivHI/LO        divider done flag, remainder and quotient
//   MultStart, DivStart      start pulses to the datapaths
//   Stall                    pipeline hold (combinational)
//   Done, Error, ErrCode     completion / abort pulses and abort reason
//   HI, LO                   architectural HI/LO registers
//   DbgState                 current FSM state, for observation
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             OpMult,
  input  logic             OpDiv,
  input  logic             DivisorZero,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             MultStop,
  input  logic [WIDTH-1:0] MultHI,
  input  logic [WIDTH-1:0] MultLO,
  input  logic             DivStop,
  input  logic [WIDTH-1:0] DivHI,
  input  logic [WIDTH-1:0] DivLO,
  output logic             MultStart,
  output logic             DivStart,
  output logic             Stall,
  output logic             Done,
  output logic             Error,
  output logic [1:0]       ErrCode,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [2:0]       DbgState
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MULT_WAIT = 3'd1,
    S_DIV_WAIT  = 3'd2,
    S_DONE      = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // The counter only needs to reach TIMEOUT-1. Once it gets there, the wait
  // state either completes or aborts in that same cycle.
  localparam int             CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;

  assign timed_out = (wait_cnt == CNT_LAST);

  // A request in IDLE stalls in its own cycle. This keeps the instruction in
  // place until the FSM has moved into a wait state (or into ERR, for a zero
  // divisor).
  assign Stall = ((state == S_IDLE) && (OpMult || OpDiv)) ||
                 (state == S_MULT_WAIT) ||
                 (state == S_DIV_WAIT);

  assign DbgState = state;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      MultStart <= 1'b0;
      DivStart  <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      ErrCode   <= ERR_NONE;
      HI        <= '0;
      LO        <= '0;
    end else begin
      // Every pulse output defaults low. It is raised only on the transition
      // into the state that owns it, which gives exactly one cycle.
      MultStart <= 1'b0;
      DivStart  <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      ErrCode   <= ERR_NONE;

      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (OpMult) begin
            // Multiply takes priority. A divide requested in the same
            // cycle is dropped.
            MultStart <= 1'b1;
            state     <= S_MULT_WAIT;
          end else if (OpDiv && DivisorZero) begin
            // A zero divisor is rejected without starting the divider.
            Error   <= 1'b1;
            ErrCode <= ERR_DIV0;
            state   <= S_ERR;
          end else if (OpDiv) begin
            DivStart <= 1'b1;
            state    <= S_DIV_WAIT;
          end else begin
            // MTHI/MTLO act only when no operation is requested. Both
            // writes may land in the same cycle.
            if (HiWrite) HI <= WriteData;
            if (LoWrite) LO <= WriteData;
          end
        end

        S_MULT_WAIT: begin
          // If the result arrives in the final allowed cycle, it is still
          // taken: Stop is checked before the timeout.
          if (MultStop) begin
            HI       <= MultHI;
            LO       <= MultLO;
            Done     <= 1'b1;
            wait_cnt <= '0;
            state    <= S_DONE;
          end else if (timed_out) begin
            Error    <= 1'b1;
            ErrCode  <= ERR_TIMEOUT;
            wait_cnt <= '0;
            state    <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DIV_WAIT: begin
          if (DivStop) begin
            HI       <= DivHI;
            LO       <= DivLO;
            Done     <= 1'b1;
            wait_cnt <= '0;
            state    <= S_DONE;
          end else if (timed_out) begin
            Error    <= 1'b1;
            ErrCode  <= ERR_TIMEOUT;
            wait_cnt <= '0;
            state    <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // DONE and ERR last one cycle each. Their pulses were registered on
        // the way in and are cleared by the defaults above.
        S_DONE: state <= S_IDLE;
        S_ERR:  state <= S_IDLE;

        default: begin
          wait_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//
// Directed testbench for muldiv_ctrl.
//
// Each operation pushes its expected outcome into exp_q. The packed entry
// holds: error flag, error code, HI, LO, and the absolute cycle in which the
// Done/Error pulse must appear. A monitor running on the falling edge pops
// one entry whenever Done or Error is high and compares the fields. Per-cycle
// behaviour (Stall, start pulses, HI/LO holding) is checked directly in the
// driver.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

  localparam int W       = 32;
  localparam int TIMEOUT = 64;
  localparam int EXP_W   = 1 + 2 + 2 * W + 32;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic         OpMult, OpDiv, DivisorZero, HiWrite, LoWrite;
  logic [W-1:0] WriteData;
  logic         MultStop, DivStop;
  logic [W-1:0] MultHI, MultLO, DivHI, DivLO;
  logic         MultStart, DivStart, Stall, Done, Error;
  logic [1:0]   ErrCode;
  logic [W-1:0] HI, LO;
  logic [2:0]   DbgState;

  muldiv_ctrl #(.WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset),
    .OpMult(OpMult), .OpDiv(OpDiv), .DivisorZero(DivisorZero),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .MultStop(MultStop), .MultHI(MultHI), .MultLO(MultLO),
    .DivStop(DivStop), .DivHI(DivHI), .DivLO(DivLO),
    .MultStart(MultStart), .DivStart(DivStart), .Stall(Stall),
    .Done(Done), .Error(Error), .ErrCode(ErrCode),
    .HI(HI), .LO(LO), .DbgState(DbgState)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] hi_m, lo_m;   // expected architectural HI/LO

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic sample();
    @(negedge Clock);
  endtask

  task automatic clear_inputs();
    OpMult = 0; OpDiv = 0; DivisorZero = 0;
    HiWrite = 0; LoWrite = 0; WriteData = '0;
    MultStop = 0; MultHI = '0; MultLO = '0;
    DivStop = 0; DivHI = '0; DivLO = '0;
  endtask

  // Issues one operation in the current IDLE cycle (cycle 0) and runs it until
  // the cycle after the last stalled cycle.
  //   stop_at    : cycle of the matching Stop, or -1 if no Stop is sent
  //   last_stall : hand-computed last cycle in which Stall must be high
  // Also injected, to confirm they are ignored: a non-matching Stop in cycle 2
  // and an MTHI/MTLO write in cycle 3.
  task automatic run_op(input string tag, input bit do_mult, input bit do_div, input bit dz,
                        input int stop_at, input logic [W-1:0] rhi, input logic [W-1:0] rlo,
                        input int last_stall);
    bit         ok;
    logic [1:0] code;
    logic [W-1:0] old_hi;
    int c0;
    ok     = (stop_at >= 0);
    code   = dz ? 2'b01 : (ok ? 2'b00 : 2'b10);
    old_hi = hi_m;
    c0     = cyc;
    exp_q.push_back({!ok, code, ok ? rhi : hi_m, ok ? rlo : lo_m, 32'(c0 + last_stall + 1)});
    OpMult = do_mult; OpDiv = do_div; DivisorZero = dz;
    for (int i = 0; i <= last_stall + 1; i++) begin
      sample();
      check({tag, "_stall"}, Stall, (i <= last_stall));
      check({tag, "_mstart"}, MultStart, (do_mult && i == 1));
      check({tag, "_dstart"}, DivStart, (!do_mult && do_div && !dz && i == 1));
      if (i == 1 || (i == 4 && i <= last_stall)) check({tag, "_hi_hold"}, HI, old_hi);
      if (i == last_stall + 1) begin
        check({tag, "_hi_end"}, HI, ok ? rhi : hi_m);
        check({tag, "_lo_end"}, LO, ok ? rlo : lo_m);
      end
      next_cycle();
      clear_inputs();
      if (i + 1 == stop_at) begin
        if (do_mult) begin MultStop = 1; MultHI = rhi; MultLO = rlo; end
        else         begin DivStop  = 1; DivHI  = rhi; DivLO  = rlo; end
      end
      if (i + 1 == 2 && 2 <= last_stall) begin
        if (do_mult) begin DivStop  = 1; DivHI  = ~rhi; DivLO  = ~rlo; end
        else         begin MultStop = 1; MultHI = ~rhi; MultLO = ~rlo; end
      end
      if (i + 1 == 3 && 3 <= last_stall) begin
        HiWrite = 1; LoWrite = 1; WriteData = 32'hBBBB_BBBB;
      end
    end
    if (ok) begin hi_m = rhi; lo_m = rlo; end
  endtask

  // ---------------- monitor ----------------
  logic [EXP_W-1:0] m_ent;
  logic             m_err;
  logic [1:0]       m_code;
  logic [W-1:0]     m_hi, m_lo;
  logic [31:0]      m_cyc;

  always @(negedge Clock) begin
    if (Reset === 1'b1 && (Done === 1'b1 || Error === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: Done=%0b Error=%0b with nothing expected (cycle %0d)",
                 Done, Error, cyc);
      end else begin
        m_ent = exp_q.pop_front();
        {m_err, m_code, m_hi, m_lo, m_cyc} = m_ent;
        check("out_done",  Done,    !m_err);
        check("out_error", Error,   m_err);
        check("out_code",  ErrCode, m_code);
        check("out_hi",    HI,      m_hi);
        check("out_lo",    LO,      m_lo);
        check("out_cycle", cyc,     m_cyc);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    Reset = 0;
    clear_inputs();
    hi_m = '0;
    lo_m = '0;
    repeat (2) @(posedge Clock);
    sample();
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_mstart", MultStart, 0);
    check("rst_dstart", DivStart, 0);
    check("rst_stall", Stall, 0);
    check("rst_done", {Done, Error, ErrCode}, 0);
    check("rst_state", DbgState, 0);
    next_cycle();
    Reset = 1;
    next_cycle();

    // MTHI + MTLO in one cycle, no stall, visible next cycle
    HiWrite = 1; LoWrite = 1; WriteData = 32'hA5A5_0001;
    sample();
    check("mt_stall", Stall, 0);
    next_cycle();
    clear_inputs();
    hi_m = 32'hA5A5_0001; lo_m = 32'hA5A5_0001;
    sample();
    check("mt_hi", HI, hi_m);
    check("mt_lo", LO, lo_m);
    next_cycle();
    LoWrite = 1; WriteData = 32'h0BAD_F00D;
    next_cycle();
    clear_inputs();
    lo_m = 32'h0BAD_F00D;
    sample();
    check("mtlo_lo", LO, lo_m);
    check("mtlo_hi", HI, hi_m);

    // Stop strobes while in IDLE must be ignored
    next_cycle();
    MultStop = 1; MultHI = 32'h1111_1111; MultLO = 32'h2222_2222;
    DivStop = 1; DivHI = 32'h3333_3333; DivLO = 32'h4444_4444;
    next_cycle();
    clear_inputs();
    sample();
    check("idle_stop_hi", HI, hi_m);
    check("idle_stop_lo", LO, lo_m);
    check("idle_stop_state", DbgState, 0);
    next_cycle();

    // -2 x 1: stop in cycle 34, Done in 35, stall cycles 0..34
    run_op("mult", 1, 0, 0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    // Divide by zero: ERR in cycle 1, stall only in cycle 0
    run_op("div0", 0, 1, 1, -1, '0, '0, 0);
    // Divide timeout: DivStart in cycle 1, Error in cycle 65
    run_op("divto", 0, 1, 0, -1, '0, '0, 64);
    // Both ops with HiWrite: multiply wins, write dropped
    HiWrite = 1; WriteData = 32'h0000_1234;
    run_op("both", 1, 1, 0, 3, 32'h1111_0000, 32'h0000_2222, 3);
    HiWrite = 1; WriteData = 32'h0000_1234;
    next_cycle();
    clear_inputs();
    hi_m = 32'h0000_1234;
    sample();
    check("hiw_after_hi", HI, hi_m);
    check("hiw_after_lo", LO, lo_m);
    next_cycle();
    // Stop in the same cycle as the timeout: Done wins
    run_op("race", 1, 0, 0, 64, 32'h8000_0001, 32'h7FFF_FFFF, 64);
    // Normal divide
    run_op("div", 0, 1, 0, 5, 32'h0000_0007, 32'h0000_0010, 5);

    // Reset in the middle of MULT_WAIT
    OpMult = 1;
    next_cycle();
    OpMult = 0;
    #1;
    check("mrst_mstart_pre", MultStart, 1);
    Reset = 0;
    #1;
    hi_m = '0; lo_m = '0;
    check("mrst_hi", HI, 0);
    check("mrst_lo", LO, 0);
    check("mrst_mstart", MultStart, 0);
    check("mrst_stall", Stall, 0);
    check("mrst_state", DbgState, 0);
    next_cycle();
    Reset = 1;
    repeat (3) next_cycle();
    MultStop = 1; MultHI = 32'hCAFE_0000; MultLO = 32'h0000_CAFE;
    next_cycle();
    clear_inputs();
    sample();
    check("mrst_late_hi", HI, 0);
    check("mrst_late_lo", LO, 0);
    check("mrst_late_stall", Stall, 0);

    repeat (3) next_cycle();
    check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
